elab_walk_gen: RTL



---
 rtl/elab_pkg.sv | 14 +
 rtl/elab_onehot_dec.sv | 37 +++
 rtl/elab_walk_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/elab_pkg.sv
// Shared definitions for the elab walk generator and its downstream checker.
package elab_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned REPS_W    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWalk,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/elab_onehot_dec.sv
// Registered decoder: walking index -> one-hot vect and thermometer w (bits above idx).
module elab_onehot_dec #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             skip,
  input  logic [IW-1:0]    idx,
  output logic [WIDTH-1:0] vect,
  output logic [WIDTH-1:0] w
);

  logic [WIDTH-1:0] vect_d;
  logic [WIDTH-1:0] w_d;

  always_comb begin
    vect_d = '0;
    w_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vect_d[i] = en && !skip && (IW'(i) == idx);
      w_d[i]    = en && (IW'(i) > idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vect <= '0;
      w    <= '0;
    end else begin
      vect <= vect_d;
      w    <= w_d;
    end
  end

endmodule

// File: rtl/elab_walk_gen.sv
// Walking one-hot stimulus generator (trig/vect/w) with start/busy/done, repeats and abort.
// Optional ELAB_WALK_ERR_INJECT_EN adds err_inj to drop index WIDTH/2 on the first pass.
module elab_walk_gen
  import elab_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned GAP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REPS_W-1:0] reps,
  input  logic              abort,
`ifdef ELAB_WALK_ERR_INJECT_EN
  input  logic              err_inj,
`endif
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              trig,
  output logic [WIDTH-1:0]  vect,
  output logic [WIDTH-1:0]  w
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IW-1:0] IdxMax  = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IdxSkip = IW'(WIDTH / 2);
  localparam logic [GW-1:0] GapLast = GW'((GAP > 0) ? GAP - 1 : 0);

  if (WIDTH < 2) begin : g_width_chk
    $error("elab_walk_gen: WIDTH must be >= 2");
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [REPS_W-1:0] rem_q, rem_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              skip_q, skip_d;
  logic              busy_d, done_d, aborted_d, trig_d;
  logic              dec_en, dec_skip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      skip_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      trig    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      skip_q  <= skip_d;
      busy    <= busy_d;
      done    <= done_d;
      aborted <= aborted_d;
      trig    <= trig_d;
    end
  end

  // rem_q holds the passes still to run after the current one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    skip_d  = skip_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StWalk;
          idx_d   = IdxMax;
          rem_d   = (reps == '0) ? '0 : reps - REPS_W'(1);
`ifdef ELAB_WALK_ERR_INJECT_EN
          skip_d  = err_inj;
`else
          skip_d  = 1'b0;
`endif
        end
      end
      StWalk: begin
        if (abort) begin
          state_d = StIdle;
        end else if (idx_q == '0) begin
          skip_d = 1'b0;
          if (rem_q == '0) begin
            state_d = StDone;
          end else begin
            rem_d = rem_q - REPS_W'(1);
            if (GAP == 0) begin
              idx_d = IdxMax;
            end else begin
              state_d = StGap;
              gap_d   = GapLast;
            end
          end
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StIdle;
        end else if (gap_q == '0) begin
          state_d = StWalk;
          idx_d   = IdxMax;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with state_q.
  always_comb begin
    busy_d    = (state_d == StWalk) || (state_d == StGap);
    done_d    = (state_d == StDone);
    trig_d    = (state_d == StWalk) && (idx_d == IdxMax);
    aborted_d = abort && ((state_q == StWalk) || (state_q == StGap));
    dec_en    = (state_d == StWalk);
    dec_skip  = skip_d && (idx_d == IdxSkip);
  end

  elab_onehot_dec #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dec_en),
    .skip  (dec_skip),
    .idx   (idx_d),
    .vect  (vect),
    .w     (w)
  );

endmodule
